// File: rtl/relay_rf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : relay_rf_pkg                                              |
// | Purpose  : Shared types and defaults for the relay register bank:   |
// |            op-code enum, FSM state enum, default widths and the     |
// |            settle-counter width helper.                             |
// | Ports    : none (package)                                           |
// | Revision : 1.0 - initial parametrised register bank                 |
// +----------------------------------------------------------------------+
package relay_rf_pkg;

   localparam int RF_DATA_W   = 8;
   localparam int RF_NUM_REGS = 8;
   localparam int RF_SETTLE   = 2;
   localparam int OP_W        = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 3'd0,
      OP_LD8   = 3'd1,
      OP_MOV8  = 3'd2,
      OP_CLR   = 3'd3,
      OP_LD16  = 3'd4,
      OP_INC16 = 3'd5
   } relay_op_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_COMMIT = 2'd2
   } relay_state_e;

   // Bits needed to hold SETTLE-1 (the largest value ever loaded).
   function automatic int cnt_width(input int settle);
      return (settle < 3) ? 1 : $clog2(settle);
   endfunction

endpackage
`default_nettype wire

// File: rtl/relay_settle_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : relay_settle_timer                                        |
// | Purpose  : Loadable down-counter with zero flag, used to model the  |
// |            settle time of relay-switched storage.                   |
// | Ports    : clk, rst_n   - clock, async active-low reset             |
// |            load_i       - load counter with load_val_i              |
// |            load_val_i   - value to load                             |
// |            dec_i        - decrement (saturates at zero)             |
// |            zero_o       - counter is zero                           |
// | Revision : 1.0 - initial version                                    |
// +----------------------------------------------------------------------+
module relay_settle_timer
   import relay_rf_pkg::*;
#(
   parameter int CNT_W = cnt_width(RF_SETTLE)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/relay_reg_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : relay_reg_bank                                            |
// | Purpose  : Bank of NUM_REGS relay registers with 8-bit and pair     |
// |            (address-width) ops behind a settle-timed handshake.     |
// | Ports    : clk, rst_n            - clock, async active-low reset    |
// |            req_valid/req_ready   - op handshake                     |
// |            req_op/dst/src        - op code, dest / pair, source     |
// |            data_in, addr_in      - LD8 / LD16 load values           |
// |            rd_sel -> rd_data     - 8-bit combinational read         |
// |            pair_sel -> addr_out  - pair combinational read          |
// |            alu_b, alu_c          - fixed operand taps               |
// |            done, err, carry      - one-cycle commit status          |
// | Revision : 1.0 - initial parametrised register bank                 |
// +----------------------------------------------------------------------+
module relay_reg_bank
   import relay_rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int NUM_REGS = RF_NUM_REGS,
   parameter int SETTLE   = RF_SETTLE,
   parameter int B_IDX    = 1,
   parameter int C_IDX    = 2,
   localparam int IW      = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [OP_W-1:0]     req_op,
   input  logic [IW-1:0]       req_dst,
   input  logic [IW-1:0]       req_src,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [2*DATA_W-1:0] addr_in,
   input  logic [IW-1:0]       rd_sel,
   output logic [DATA_W-1:0]   rd_data,
   input  logic [IW-2:0]       pair_sel,
   output logic [2*DATA_W-1:0] addr_out,
   output logic [DATA_W-1:0]   alu_b,
   output logic [DATA_W-1:0]   alu_c,
   output logic                done,
   output logic                err,
   output logic                carry
);

   localparam int CNT_W = cnt_width(SETTLE);

   relay_state_e          state_q;
   relay_op_e             op_q;
   logic [IW-1:0]         dst_q;
   logic [IW-1:0]         src_q;
   logic [DATA_W-1:0]     data_q;
   logic [2*DATA_W-1:0]   addr_q;
   logic [DATA_W-1:0]     regs_q [NUM_REGS];
   logic [DATA_W-1:0]     regs_d [NUM_REGS];
   logic                  done_q;
   logic                  err_q;
   logic                  err_d;
   logic                  carry_q;
   logic                  carry_d;

   logic                  accept;
   logic                  settle_zero;
   logic [IW-1:0]         pair_hi;
   logic [IW-1:0]         pair_lo;
   logic                  pair_ok;
   logic                  dst_ok;
   logic                  src_ok;
   logic [2*DATA_W:0]     inc_sum;
   logic [IW-1:0]         rd_hi;
   logic [IW-1:0]         rd_lo;

   assign accept = (state_q == ST_IDLE) && req_valid;

   relay_settle_timer #(
      .CNT_W (CNT_W)
   ) u_settle (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (accept),
      .load_val_i (CNT_W'(SETTLE - 1)),
      .dec_i      (state_q == ST_SETTLE),
      .zero_o     (settle_zero)
   );

   // Pair k occupies {reg[2k], reg[2k+1]}; only the pair bits of dst count.
   assign pair_hi = {dst_q[IW-2:0], 1'b0};
   assign pair_lo = {dst_q[IW-2:0], 1'b1};
   // With a non power-of-two bank the top pair may not exist; such a pair op
   // is silently a no-op rather than an error.
   assign pair_ok = int'(pair_lo) < NUM_REGS;
   assign dst_ok  = int'(dst_q) < NUM_REGS;
   assign src_ok  = int'(src_q) < NUM_REGS;
   assign inc_sum = {1'b0, regs_q[pair_hi], regs_q[pair_lo]} + (2*DATA_W+1)'(1);

   // Register image after the captured op commits, evaluated against
   // committed state so MOV8 sees the source value at commit time.
   always_comb begin
      regs_d  = regs_q;
      err_d   = 1'b0;
      carry_d = 1'b0;
      case (op_q)
         OP_NOP: begin
         end
         OP_LD8: begin
            if (dst_ok) regs_d[dst_q] = data_q;
            else        err_d = 1'b1;
         end
         OP_MOV8: begin
            if (dst_ok && src_ok) regs_d[dst_q] = regs_q[src_q];
            else                  err_d = 1'b1;
         end
         OP_CLR: begin
            if (dst_ok) regs_d[dst_q] = '0;
            else        err_d = 1'b1;
         end
         OP_LD16: begin
            if (pair_ok) begin
               regs_d[pair_hi] = addr_q[2*DATA_W-1:DATA_W];
               regs_d[pair_lo] = addr_q[DATA_W-1:0];
            end
         end
         OP_INC16: begin
            if (pair_ok) begin
               regs_d[pair_hi] = inc_sum[2*DATA_W-1:DATA_W];
               regs_d[pair_lo] = inc_sum[DATA_W-1:0];
               carry_d         = inc_sum[2*DATA_W];
            end
         end
         default: begin
            err_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         dst_q   <= '0;
         src_q   <= '0;
         data_q  <= '0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         carry_q <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         carry_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q    <= relay_op_e'(req_op);
                  dst_q   <= req_dst;
                  src_q   <= req_src;
                  data_q  <= data_in;
                  addr_q  <= addr_in;
                  state_q <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_zero) state_q <= ST_COMMIT;
            end
            ST_COMMIT: begin
               regs_q  <= regs_d;
               done_q  <= 1'b1;
               err_q   <= err_d;
               carry_q <= carry_d;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign carry     = carry_q;

   // Read ports: committed state only; out-of-range selects read as zero.
   assign rd_hi    = {pair_sel, 1'b0};
   assign rd_lo    = {pair_sel, 1'b1};
   assign rd_data  = (int'(rd_sel) < NUM_REGS) ? regs_q[rd_sel] : '0;
   assign addr_out = (int'(rd_lo) < NUM_REGS) ? {regs_q[rd_hi], regs_q[rd_lo]} : '0;
   assign alu_b    = regs_q[B_IDX];
   assign alu_c    = regs_q[C_IDX];

endmodule
`default_nettype wire
